fetch_unit: RTL and testbench

Instruction fetch and program sequencer that feeds the 24-bit instruction register consumed by the microinstruction decoder. It owns the 12-bit program counter. It reads program memory through a request/valid handshake and presents each instruction to the decoder with a valid/ready handshake. It resolves control-group instructions (JMP, JZE, JNE, JCY, BSR, RET) using datapath flags and an internal return stack.

---
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit.sv | 133 +++++++++++++
 tb/tb_fetch_unit.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch sequencer, program memory and the decoder.
// master is the fetch unit side; slave is the memory/decoder/datapath side.
interface fetch_unit_if;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic [23:0] mem_rdata;
  logic        mem_valid;
  logic [23:0] ir;
  logic        ir_valid;
  logic        ir_ready;
  logic        flag_z;
  logic        flag_cy;
  logic        flags_valid;
  logic [11:0] pc;
  logic        halted;
  logic [1:0]  err;

  modport master (
    output mem_req, mem_addr, ir, ir_valid, pc, halted, err,
    input  mem_rdata, mem_valid, ir_ready, flag_z, flag_cy, flags_valid
  );

  modport slave (
    input  mem_req, mem_addr, ir, ir_valid, pc, halted, err,
    output mem_rdata, mem_valid, ir_ready, flag_z, flag_cy, flags_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch and program sequencer: owns pc, fetches over a req/valid
// bus, issues ir to the decoder and resolves control-group flow with a return stack.
module fetch_unit #(
  parameter logic [11:0] RESET_PC    = 12'h000,
  parameter int          STACK_DEPTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);
  localparam int SPW = $clog2(STACK_DEPTH) + 1;

  localparam logic [7:0] OP_JMP = 8'h00;
  localparam logic [7:0] OP_JZE = 8'h01;
  localparam logic [7:0] OP_JNE = 8'h02;
  localparam logic [7:0] OP_JCY = 8'h03;
  localparam logic [7:0] OP_RET = 8'h04;
  localparam logic [7:0] OP_BSR = 8'h05;

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;

  state_t      state;
  logic [11:0] pc;
  logic [23:0] ir;
  logic [SPW-1:0] sp;
  logic        halted;
  logic [1:0]  err;
  logic [11:0] stack [STACK_DEPTH];

  logic [11:0]    pc_inc, pc_nxt, tgt;
  logic [7:0]     op;
  logic           is_ctl, is_cond, ir_valid, hs;
  logic           full, empty, do_push, do_pop;
  logic [1:0]     fault;
  logic [SPW-1:0] sp_dec;

  assign op      = ir[19:12];
  assign tgt     = ir[11:0];
  assign is_ctl  = (ir[23:20] == 4'h1);
  assign is_cond = is_ctl && (op == OP_JZE || op == OP_JNE || op == OP_JCY);
  assign pc_inc  = pc + 12'd1;
  assign sp_dec  = sp - SPW'(1);
  assign full    = (sp == SPW'(STACK_DEPTH));
  assign empty   = (sp == '0);

  // Conditional branches are not offered until the flags are trustworthy.
  assign ir_valid = (state == ISSUE) && (!is_cond || bus.flags_valid);
  assign hs       = ir_valid && bus.ir_ready;

  assign bus.mem_req  = (state == FETCH);
  assign bus.mem_addr = pc;
  assign bus.ir       = ir;
  assign bus.ir_valid = ir_valid;
  assign bus.pc       = pc;
  assign bus.halted   = halted;
  assign bus.err      = err;

  always_comb begin
    pc_nxt  = pc_inc;
    do_push = 1'b0;
    do_pop  = 1'b0;
    fault   = 2'b00;
    if (is_ctl) begin
      case (op)
        OP_JMP: pc_nxt = tgt;
        OP_JZE: if (bus.flag_z)  pc_nxt = tgt;
        OP_JNE: if (!bus.flag_z) pc_nxt = tgt;
        OP_JCY: if (bus.flag_cy) pc_nxt = tgt;
        OP_RET: begin
          if (empty) begin
            fault  = 2'b10;
            pc_nxt = pc;
          end else begin
            do_pop = 1'b1;
            pc_nxt = stack[sp_dec[SPW-2:0]];
          end
        end
        OP_BSR: begin
          if (full) begin
            fault  = 2'b01;
            pc_nxt = pc;
          end else begin
            do_push = 1'b1;
            pc_nxt  = tgt;
          end
        end
        default: pc_nxt = pc_inc;
      endcase
    end
  end

  // Stack storage needs no reset: sp alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (rst_n && hs && do_push)
      stack[sp[SPW-2:0]] <= pc_inc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      ir     <= 24'h000000;
      sp     <= '0;
      halted <= 1'b0;
      err    <= 2'b00;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (bus.mem_valid) begin
            ir    <= bus.mem_rdata;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (hs) begin
            pc <= pc_nxt;
            if (fault != 2'b00) begin
              state  <= HALT;
              halted <= 1'b1;
              err    <= fault;
            end else begin
              state <= FETCH;
              if (do_push) sp <= sp + SPW'(1);
              if (do_pop)  sp <= sp_dec;
            end
          end
        end
        default: state <= HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory responder queues expected issues
// from a queue-based program model; a monitor pops and compares on each handshake.
module tb_fetch_unit;
  localparam logic [11:0] RST_PC = 12'h000;
  localparam int          DEPTH  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus();
  fetch_unit #(.RESET_PC(RST_PC), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    logic [11:0] pc;
    logic [23:0] ir;
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] mem [4096];
  logic [11:0] rstack[$];
  logic [11:0] ref_pc = RST_PC;
  bit          ref_halted = 1'b0;
  logic [1:0]  ref_err = 2'b00;
  int          hs_count = 0;
  int          hs_cycles[$];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          resp_mode = 0;   // 0 random wait, 1 two waits, 2 never answer, 3 force valid
  int          ready_mode = 1;  // 0 random, 1 always, 2 never
  int          flag_mode = 0;   // 0 random, 1 z=cy=1, 2 flags invalid, 3 z=cy=0

  function automatic void chk_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endfunction

  function automatic bit is_cond(input logic [23:0] i);
    return (i[23:20] == 4'h1) && (i[19:12] >= 8'h01) && (i[19:12] <= 8'h03);
  endfunction

  function automatic logic [23:0] rand_instr();
    logic [23:0] r;
    logic [11:0] t;
    r = 24'($urandom);
    t = 12'($urandom_range(0, 63));
    case ($urandom_range(0, 11))
      0, 1, 2, 3: if (r[23:20] == 4'h1) r[23:20] = 4'h3;
      4:          r = {4'h1, 8'($urandom_range(6, 255)), r[11:0]};
      5, 6:       r = {4'h1, 8'h00, t};
      7, 8:       r = {4'h1, 8'($urandom_range(1, 3)), t};
      9, 10:      r = {4'h1, 8'h05, t};
      default:    r = {4'h1, 8'h04, r[11:0]};
    endcase
    return r;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 24'h000000;
  endtask

  // Program-level reference: next pc from the architectural rules only.
  task automatic model_step(input logic [23:0] i);
    logic [11:0] nx;
    nx = ref_pc + 12'd1;
    if (i[23:20] == 4'h1) begin
      case (i[19:12])
        8'h00: nx = i[11:0];
        8'h01: if (bus.flag_z)  nx = i[11:0];
        8'h02: if (!bus.flag_z) nx = i[11:0];
        8'h03: if (bus.flag_cy) nx = i[11:0];
        8'h04: begin
          if (rstack.size() == 0) begin
            ref_halted = 1'b1; ref_err = 2'b10; nx = ref_pc;
          end else nx = rstack.pop_back();
        end
        8'h05: begin
          if (rstack.size() == DEPTH) begin
            ref_halted = 1'b1; ref_err = 2'b01; nx = ref_pc;
          end else begin
            rstack.push_back(ref_pc + 12'd1);
            nx = i[11:0];
          end
        end
        default: nx = ref_pc + 12'd1;
      endcase
    end
    ref_pc = nx;
  endtask

  // Memory responder: answers requests and queues the instruction the model expects next.
  initial begin
    int  wcnt;
    bit  busy;
    wcnt = 0; busy = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_rdata = 24'h0;
    forever begin
      @(posedge clk); #1;
      bus.mem_valid = 1'b0;
      bus.mem_rdata = 24'($urandom);
      if (resp_mode == 3) begin
        bus.mem_valid = 1'b1;
      end else if (bus.mem_req && resp_mode != 2) begin
        if (!busy) begin
          busy = 1'b1;
          wcnt = (resp_mode == 1) ? 2 : $urandom_range(0, 3);
        end
        if (wcnt == 0) begin
          bus.mem_valid = 1'b1;
          bus.mem_rdata = mem[bus.mem_addr];
          busy = 1'b0;
          if (rst_n && !ref_halted) exp_q.push_back(exp_t'{ref_pc, mem[ref_pc]});
        end else wcnt--;
      end else if (!bus.mem_req) begin
        busy = 1'b0;
        if (resp_mode == 0) bus.mem_valid = ($urandom_range(0, 3) == 0);
      end
    end
  end

  initial begin
    bus.ir_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       bus.ir_ready = ($urandom_range(0, 3) != 0);
        1:       bus.ir_ready = 1'b1;
        default: bus.ir_ready = 1'b0;
      endcase
    end
  end

  initial begin
    bus.flag_z = 1'b0; bus.flag_cy = 1'b0; bus.flags_valid = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (flag_mode)
        0: begin
          bus.flag_z = 1'($urandom); bus.flag_cy = 1'($urandom);
          bus.flags_valid = ($urandom_range(0, 4) != 0);
        end
        1: begin bus.flag_z = 1'b1; bus.flag_cy = 1'b1; bus.flags_valid = 1'b1; end
        2: begin bus.flag_z = 1'($urandom); bus.flag_cy = 1'($urandom); bus.flags_valid = 1'b0; end
        default: begin bus.flag_z = 1'b0; bus.flag_cy = 1'b0; bus.flags_valid = 1'b1; end
      endcase
    end
  end

  // Monitor: compares on every handshake, independent of stimulus.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        ref_pc = RST_PC; ref_halted = 1'b0; ref_err = 2'b00;
        rstack.delete(); exp_q.delete(); hs_cycles.delete(); hs_count = 0;
      end else if (ref_halted) begin
        chk_eq("halt_state", 32'({bus.halted, bus.err, bus.mem_req, bus.ir_valid}),
               32'({1'b1, ref_err, 1'b0, 1'b0}));
      end else begin
        chk_eq("no_halt", 32'({bus.halted, bus.err}), 32'h0);
        if (bus.mem_req) chk_eq("mem_addr", 32'(bus.mem_addr), 32'(ref_pc));
        if (bus.ir_valid && exp_q.size() > 0 && is_cond(exp_q[0].ir))
          chk_eq("cond_gate", 32'(bus.flags_valid), 32'h1);
        if (bus.ir_valid && bus.ir_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL sb_empty: issue of ir=%0h with nothing expected", bus.ir);
          end else begin
            e = exp_q.pop_front();
            chk_eq("issue_pc", 32'(bus.pc), 32'(e.pc));
            chk_eq("issue_ir", 32'(bus.ir), 32'(e.ir));
            model_step(e.ir);
            hs_count++;
            hs_cycles.push_back(cyc);
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_vals", 32'({bus.pc, bus.ir_valid, bus.mem_req, bus.halted, bus.err}),
           32'({RST_PC, 1'b0, 1'b0, 1'b0, 2'b00}));
    chk_eq("rst_ir", 32'(bus.ir), 32'h0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk_eq("idle_req", 32'(bus.mem_req), 32'h0);
    @(negedge clk);
    if (resp_mode != 3) chk_eq("fetch_req", 32'(bus.mem_req), 32'h1);
  endtask

  task automatic wait_hs(input int n, input int budget, input string nm);
    int c;
    c = 0;
    while (hs_count < n && !ref_halted && c < budget) begin
      @(posedge clk); #3;
      c++;
    end
    if (hs_count < n && !ref_halted) begin
      n_tests++; n_fail++;
      $display("FAIL %s: timeout with %0d of %0d handshakes", nm, hs_count, n);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #3; end
  endtask

  initial begin
    logic [23:0] ir_hold;
    logic [11:0] pc_hold;
    int          c;

    // Sequential fetch with two wait states: 4 cycles per instruction.
    clear_mem();
    mem[0] = 24'h200001; mem[1] = 24'h800022; mem[2] = 24'h400040;
    resp_mode = 1; ready_mode = 1; flag_mode = 0;
    do_reset();
    wait_hs(3, 100, "seq");
    chk_eq("seq_pc", 32'(bus.pc), 32'h3);
    if (hs_cycles.size() >= 3) begin
      chk_eq("seq_gap1", 32'(hs_cycles[1] - hs_cycles[0]), 32'd4);
      chk_eq("seq_gap2", 32'(hs_cycles[2] - hs_cycles[1]), 32'd4);
    end

    // JMP, then JZE held until flags are valid, then JCY and JNE.
    clear_mem();
    mem[12'h000] = 24'h100005; mem[12'h005] = 24'h100123; mem[12'h123] = 24'h101050;
    mem[12'h050] = 24'h103200; mem[12'h200] = 24'h102300;
    resp_mode = 0; flag_mode = 2;
    do_reset();
    wait_hs(2, 100, "jmp");
    cycles(20);
    chk_eq("jze_hold_cnt", 32'(hs_count), 32'd2);
    chk_eq("jze_hold_ir", 32'(bus.ir), 32'h101050);
    chk_eq("jze_hold_vld", 32'(bus.ir_valid), 32'h0);
    chk_eq("jze_hold_pc", 32'(bus.pc), 32'h123);
    flag_mode = 1;
    wait_hs(3, 100, "jze_t");
    chk_eq("jze_taken", 32'(bus.pc), 32'h050);
    wait_hs(5, 100, "jcy_jne");
    chk_eq("jne_not_taken", 32'(bus.pc), 32'h201);
    flag_mode = 3;
    do_reset();
    wait_hs(3, 100, "jze_nt");
    chk_eq("jze_not_taken", 32'(bus.pc), 32'h124);

    // Nested calls and returns; a final RET underflows.
    clear_mem();
    mem[12'h000] = 24'h100010; mem[12'h010] = 24'h105100; mem[12'h100] = 24'h105200;
    mem[12'h200] = 24'h104000; mem[12'h101] = 24'h104000; mem[12'h011] = 24'h104000;
    flag_mode = 0; ready_mode = 0;
    do_reset();
    wait_hs(4, 200, "ret1");
    chk_eq("ret1_pc", 32'(bus.pc), 32'h101);
    wait_hs(5, 200, "ret2");
    chk_eq("ret2_pc", 32'(bus.pc), 32'h011);
    wait_hs(6, 200, "ret3");
    cycles(3);
    chk_eq("sp_empty_err", 32'({bus.halted, bus.err, bus.pc}), 32'({1'b1, 2'b10, 12'h011}));

    // RET directly after reset.
    clear_mem();
    mem[0] = 24'h104000;
    do_reset();
    wait_hs(1, 100, "ret_rst");
    cycles(2);
    chk_eq("ret_rst_err", 32'({bus.halted, bus.err, bus.pc}), 32'({1'b1, 2'b10, 12'h000}));

    // Nine BSRs overflow an eight-deep stack.
    clear_mem();
    for (int i = 0; i < 9; i++) mem[i] = 24'h105000 | 24'(i + 1);
    ready_mode = 1;
    do_reset();
    wait_hs(8, 200, "bsr8");
    chk_eq("bsr8_ok", 32'({bus.halted, bus.pc}), 32'({1'b0, 12'h008}));
    wait_hs(9, 200, "bsr9");
    cycles(1);
    chk_eq("ovf_err", 32'({bus.halted, bus.err, bus.pc}), 32'({1'b1, 2'b01, 12'h008}));
    cycles(5);
    chk_eq("ovf_no_req", 32'(bus.mem_req), 32'h0);

    // pc and pushed return address wrap at 12'hFFF.
    clear_mem();
    mem[12'h000] = 24'h100FFF; mem[12'hFFF] = 24'h105010; mem[12'h010] = 24'h104000;
    do_reset();
    wait_hs(1, 100, "wrap1");
    chk_eq("wrap_fff", 32'(bus.pc), 32'hFFF);
    wait_hs(3, 100, "wrap3");
    chk_eq("wrap_ret", 32'(bus.pc), 32'h000);

    // Reset mid-FETCH with mem_valid high: nothing captured.
    clear_mem();
    mem[12'h000] = 24'h100123; mem[12'h123] = 24'h200001;
    resp_mode = 1;
    do_reset();
    wait_hs(1, 100, "midrst");
    resp_mode = 2;
    cycles(3);
    resp_mode = 3;
    @(posedge clk); #2 rst_n = 1'b0;
    @(negedge clk);
    chk_eq("midrst_pre", 32'({bus.mem_req, bus.pc}), 32'({1'b1, 12'h123}));
    @(posedge clk); #3;
    chk_eq("midrst_post", 32'({bus.pc, bus.ir_valid, bus.mem_req}), 32'({RST_PC, 1'b0, 1'b0}));
    chk_eq("midrst_ir", 32'(bus.ir), 32'h0);
    resp_mode = 0;

    // Random programs, the first with a 10-cycle back-pressure window.
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 4096; i++) mem[i] = rand_instr();
      resp_mode = 0; ready_mode = (r == 0) ? 2 : 0; flag_mode = (r == 0) ? 1 : 0;
      do_reset();
      if (r == 0) begin
        c = 0;
        while (!bus.ir_valid && c < 200) begin @(posedge clk); #3; c++; end
        chk_eq("bp_valid", 32'(bus.ir_valid), 32'h1);
        ir_hold = bus.ir; pc_hold = bus.pc;
        for (int k = 0; k < 10; k++) begin
          @(posedge clk); #3;
          chk_eq("bp_hold", 32'({bus.ir, bus.pc, bus.ir_valid}), 32'({ir_hold, pc_hold, 1'b1}));
        end
        ready_mode = 0; flag_mode = 0;
      end
      wait_hs(150, 4000, "rand");
      cycles(3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
